// File: rtl/event_pkg.sv
// Shared definitions for the event-generation blocks: FSM state encoding
// and its width, kept here so related event blocks decode states identically.
package event_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

endpackage

// File: rtl/period_timer.sv
// Period down-counter: loads a start value, counts down while enabled,
// holds when disabled and flags zero.
module period_timer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             dec,
   input  logic [WIDTH-1:0] load_val,
   output logic             zero
);

   logic [WIDTH-1:0] count;

   // Load wins over decrement; the count saturates at zero rather than wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - WIDTH'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/event_generator.sv
// Burst tick generator: on START emits NUM_EVENTS one-cycle TICK pulses
// spaced PERIOD enabled cycles apart, then pulses DONE.
module event_generator
   import event_pkg::*;
#(
   parameter int CNT_WIDTH    = 8,
   parameter int PERIOD_WIDTH = 8,
   parameter int HAS_ENABLE   = 0
) (
   input  logic                    ACLK,
   input  logic                    ARESET,
   input  logic                    ENABLE,
   input  logic                    START,
   input  logic                    ABORT,
   input  logic [CNT_WIDTH-1:0]    NUM_EVENTS,
   input  logic [PERIOD_WIDTH-1:0] PERIOD,
   output logic                    TICK,
   output logic                    BUSY,
   output logic                    DONE,
   output logic [CNT_WIDTH-1:0]    EMITTED
);

   state_t                  state;
   logic [CNT_WIDTH-1:0]    remaining;
   logic [PERIOD_WIDTH-1:0] reload_val;
   logic [PERIOD_WIDTH-1:0] p_m1;
   logic [PERIOD_WIDTH-1:0] load_val;
   logic                    en;
   logic                    accept;
   logic                    start_run;
   logic                    last_tick;
   logic                    reload;
   logic                    timer_load;
   logic                    timer_dec;
   logic                    timer_zero;

   assign en        = (HAS_ENABLE != 0) ? ENABLE : 1'b1;
   assign accept    = (state == ST_IDLE) && START && !ABORT && en;
   assign start_run = accept && (NUM_EVENTS != '0);

   // PERIOD=0 behaves as PERIOD=1, so the reload value is P-1 clamped at 0.
   assign p_m1 = (PERIOD == '0) ? '0 : PERIOD - PERIOD_WIDTH'(1);

   // Completion is decided by the last TICK itself, independent of ENABLE,
   // so a pause right after the final pulse cannot strand the FSM in RUN.
   assign last_tick = (state == ST_RUN) && TICK && (remaining == '0);
   assign reload    = (state == ST_RUN) && !ABORT && !last_tick && en &&
                      timer_zero && (remaining != '0);

   assign timer_load = start_run || reload;
   assign timer_dec  = (state == ST_RUN) && !ABORT && en;
   assign load_val   = start_run ? p_m1 : reload_val;

   period_timer #(
      .WIDTH(PERIOD_WIDTH)
   ) u_timer (
      .clk     (ACLK),
      .rst     (ARESET),
      .load    (timer_load),
      .dec     (timer_dec),
      .load_val(load_val),
      .zero    (timer_zero)
   );

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state      <= ST_IDLE;
         TICK       <= 1'b0;
         BUSY       <= 1'b0;
         DONE       <= 1'b0;
         EMITTED    <= '0;
         remaining  <= '0;
         reload_val <= '0;
      end else begin
         TICK <= 1'b0;
         DONE <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  reload_val <= p_m1;
                  if (NUM_EVENTS != '0) begin
                     state     <= ST_RUN;
                     TICK      <= 1'b1;
                     BUSY      <= 1'b1;
                     EMITTED   <= CNT_WIDTH'(1);
                     remaining <= NUM_EVENTS - CNT_WIDTH'(1);
                  end else begin
                     state   <= ST_FIN;
                     DONE    <= 1'b1;
                     EMITTED <= '0;
                  end
               end
            end
            ST_RUN: begin
               // ABORT outranks a same-cycle completion: no DONE, count kept.
               if (ABORT) begin
                  state <= ST_IDLE;
                  BUSY  <= 1'b0;
               end else if (last_tick) begin
                  state <= ST_FIN;
                  BUSY  <= 1'b0;
                  DONE  <= 1'b1;
               end else if (reload) begin
                  TICK      <= 1'b1;
                  remaining <= remaining - CNT_WIDTH'(1);
                  EMITTED   <= EMITTED + CNT_WIDTH'(1);
               end
            end
            ST_FIN: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
               BUSY  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_event_generator.sv
// Scoreboard bench for event_generator: expected per-cycle outputs are
// queued as each scenario is set up and popped as the DUT is clocked.
module tb_event_generator;

   typedef struct packed {
      logic       tick;
      logic       busy;
      logic       done;
      logic [7:0] emitted;
   } out_t;

   logic       ACLK = 1'b0;
   logic       ARESET = 1'b1;
   logic       ENABLE = 1'b1;
   logic       START = 1'b0;
   logic       ABORT = 1'b0;
   logic [7:0] NUM_EVENTS = '0;
   logic [7:0] PERIOD = '0;
   logic       TICK;
   logic       BUSY;
   logic       DONE;
   logic [7:0] EMITTED;

   out_t obs;
   out_t sb[$];
   int   checks = 0;
   int   errors = 0;

   event_generator #(
      .CNT_WIDTH   (8),
      .PERIOD_WIDTH(8),
      .HAS_ENABLE  (1)
   ) dut (
      .ACLK      (ACLK),
      .ARESET    (ARESET),
      .ENABLE    (ENABLE),
      .START     (START),
      .ABORT     (ABORT),
      .NUM_EVENTS(NUM_EVENTS),
      .PERIOD    (PERIOD),
      .TICK      (TICK),
      .BUSY      (BUSY),
      .DONE      (DONE),
      .EMITTED   (EMITTED)
   );

   always #5 ACLK = ~ACLK;

   function automatic string fmt(input out_t o);
      return $sformatf("tick=%b busy=%b done=%b emitted=%0d", o.tick, o.busy, o.done, o.emitted);
   endfunction

   task automatic push(input logic t, input logic b, input logic d, input int em);
      out_t e;
      e = '{tick: t, busy: b, done: d, emitted: 8'(em)};
      sb.push_back(e);
   endtask

   // Apply one cycle of inputs, clock it, sample outputs 1 time unit later.
   task automatic drive_cycle(input logic s, input logic a, input logic e);
      START  = s;
      ABORT  = a;
      ENABLE = e;
      @(posedge ACLK);
      #1;
      obs = {TICK, BUSY, DONE, EMITTED};
   endtask

   task automatic test_reset();
      out_t exp;
      ARESET = 1'b1;
      repeat (2) @(posedge ACLK);
      #1;
      obs = {TICK, BUSY, DONE, EMITTED};
      checks++;
      if (obs !== out_t'(0)) begin
         errors++;
         $display("FAIL reset_state: got %s, expected all zero", fmt(obs));
      end
      // First START after release must be taken on the very first edge.
      ARESET     = 1'b0;
      NUM_EVENTS = 8'd1;
      PERIOD     = 8'd1;
      push(1, 1, 0, 1);
      push(0, 0, 1, 1);
      push(0, 0, 0, 1);
      for (int c = 0; c < 3; c++) begin
         drive_cycle(c == 0, 0, 1);
         exp = sb.pop_front();
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL first_start cycle %0d: got %s, expected %s", c + 1, fmt(obs), fmt(exp));
         end
      end
   endtask

   task automatic test_basic();
      out_t exp;
      int   em = 0;
      NUM_EVENTS = 8'd3;
      PERIOD     = 8'd4;
      for (int c = 1; c <= 12; c++) begin
         logic t;
         t = (c == 1) || (c == 5) || (c == 9);
         if (t) em++;
         push(t, c <= 9, c == 10, em);
      end
      for (int c = 0; c < 12; c++) begin
         drive_cycle(c == 0, 0, 1);
         exp = sb.pop_front();
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL basic_n3_p4 cycle %0d: got %s, expected %s", c + 1, fmt(obs), fmt(exp));
         end
      end
   endtask

   task automatic test_short_period();
      out_t exp;
      for (int p = 0; p <= 1; p++) begin
         int em = 0;
         NUM_EVENTS = 8'd3;
         PERIOD     = 8'(p);
         for (int c = 1; c <= 6; c++) begin
            if (c <= 3) em++;
            push(c <= 3, c <= 3, c == 4, em);
         end
         for (int c = 0; c < 6; c++) begin
            drive_cycle(c == 0, 0, 1);
            exp = sb.pop_front();
            checks++;
            if (obs !== exp) begin
               errors++;
               $display("FAIL period_%0d cycle %0d: got %s, expected %s", p, c + 1, fmt(obs), fmt(exp));
            end
         end
      end
   endtask

   task automatic test_zero_events();
      out_t exp;
      NUM_EVENTS = 8'd0;
      PERIOD     = 8'd5;
      push(0, 0, 1, 0);
      push(0, 0, 0, 0);
      push(0, 0, 0, 0);
      for (int c = 0; c < 3; c++) begin
         drive_cycle(c == 0, 0, 1);
         exp = sb.pop_front();
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL zero_events cycle %0d: got %s, expected %s", c + 1, fmt(obs), fmt(exp));
         end
      end
   endtask

   task automatic test_abort();
      out_t exp;
      NUM_EVENTS = 8'd4;
      PERIOD     = 8'd2;
      for (int c = 1; c <= 7; c++)
         push(c == 1 || c == 3, c <= 4, 0, (c >= 3) ? 2 : 1);
      for (int c = 0; c < 7; c++) begin
         drive_cycle(c == 0, c == 4, 1);
         exp = sb.pop_front();
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL abort_mid cycle %0d: got %s, expected %s", c + 1, fmt(obs), fmt(exp));
         end
      end
   endtask

   task automatic test_abort_on_last_tick();
      out_t exp;
      NUM_EVENTS = 8'd2;
      PERIOD     = 8'd2;
      for (int c = 1; c <= 5; c++)
         push(c == 1 || c == 3, c <= 3, 0, (c >= 3) ? 2 : 1);
      for (int c = 0; c < 5; c++) begin
         drive_cycle(c == 0, c == 3, 1);
         exp = sb.pop_front();
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL abort_last cycle %0d: got %s, expected %s", c + 1, fmt(obs), fmt(exp));
         end
      end
   endtask

   // START alongside ABORT, or while disabled, must not be accepted in IDLE.
   task automatic test_idle_reject();
      out_t exp;
      NUM_EVENTS = 8'd3;
      PERIOD     = 8'd1;
      for (int c = 1; c <= 3; c++) push(0, 0, 0, 2);
      for (int c = 0; c < 3; c++) begin
         drive_cycle(c < 2, c == 0, c != 1);
         if (c == 1) START = 1'b0;
         exp = sb.pop_front();
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL idle_reject cycle %0d: got %s, expected %s", c + 1, fmt(obs), fmt(exp));
         end
      end
   endtask

   task automatic test_enable_pause();
      out_t exp;
      NUM_EVENTS = 8'd2;
      PERIOD     = 8'd3;
      for (int c = 1; c <= 10; c++)
         push(c == 1 || c == 7, c <= 7, c == 8, (c >= 7) ? 2 : 1);
      for (int c = 0; c < 10; c++) begin
         if (c == 1) NUM_EVENTS = 8'd9;
         drive_cycle(c == 0 || c == 3, 0, !(c >= 2 && c <= 4));
         exp = sb.pop_front();
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL enable_pause cycle %0d: got %s, expected %s", c + 1, fmt(obs), fmt(exp));
         end
      end
   endtask

   // START held high: ignored in RUN and FIN, taken again once back in IDLE.
   task automatic test_back_to_back();
      out_t exp;
      NUM_EVENTS = 8'd1;
      PERIOD     = 8'd1;
      for (int c = 1; c <= 6; c++)
         push(c == 1 || c == 4, c == 1 || c == 4, c == 2 || c == 5, 1);
      for (int c = 0; c < 6; c++) begin
         drive_cycle(c <= 3, 0, 1);
         exp = sb.pop_front();
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL back_to_back cycle %0d: got %s, expected %s", c + 1, fmt(obs), fmt(exp));
         end
      end
   endtask

   task automatic test_reset_midburst();
      out_t exp;
      NUM_EVENTS = 8'd5;
      PERIOD     = 8'd2;
      for (int c = 1; c <= 4; c++)
         push(c == 1 || c == 3, 1, 0, (c >= 3) ? 2 : 1);
      for (int c = 0; c < 4; c++) begin
         drive_cycle(c == 0, 0, 1);
         exp = sb.pop_front();
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL pre_reset cycle %0d: got %s, expected %s", c + 1, fmt(obs), fmt(exp));
         end
      end
      #2 ARESET = 1'b1;
      #1;
      obs = {TICK, BUSY, DONE, EMITTED};
      checks++;
      if (obs !== out_t'(0)) begin
         errors++;
         $display("FAIL midburst_reset: got %s, expected all zero", fmt(obs));
      end
      #1 ARESET = 1'b0;
      NUM_EVENTS = 8'd2;
      PERIOD     = 8'd1;
      push(1, 1, 0, 1);
      push(1, 1, 0, 2);
      push(0, 0, 1, 2);
      push(0, 0, 0, 2);
      for (int c = 0; c < 4; c++) begin
         drive_cycle(c == 0, 0, 1);
         exp = sb.pop_front();
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL post_reset cycle %0d: got %s, expected %s", c + 1, fmt(obs), fmt(exp));
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_short_period();
      test_zero_events();
      test_abort();
      test_abort_on_last_tick();
      test_idle_reject();
      test_enable_pause();
      test_back_to_back();
      test_reset_midburst();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
